// File: rtl/serial_fifo_uart.sv
// Kraft80 second-generation UART on the Z80 strobe bus: programmable baud divisor,
// 16x oversampled receiver, RX/TX FIFOs, sticky error flags, auto-RTS and one interrupt line.
module serial_fifo_uart #(
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [3:0]  BASE_ADDR      = 4'd8,
  parameter logic [15:0] DEFAULT_DIV    = 16'd12,
  parameter int          AUTO_RTS_LEVEL = FIFO_DEPTH - 2
) (
  input  logic       cpuclk,
  input  logic       nrst,
  inout  wire  [7:0] data,
  input  logic       ncs,
  input  logic       nwr,
  input  logic       nrd,
  input  logic [3:0] addr,
  input  logic       rxd_serial,
  output logic       txd_serial,
  output logic       rts_serial,
  output logic       intr_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] RTS_LVL_C = (AW+1)'(AUTO_RTS_LEVEL);
  localparam logic [AW:0] PTR_ZERO  = {(AW+1){1'b0}};

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  logic sel_s, wr_act_s, wr_pulse_s, wr_seen_r, rd_pend_r, rd_fire_s, stat_clr_s, flush_s, div_wr_s;
  logic [1:0] rd_idx_r;
  logic rts_req_r, rx_ie_r, tx_ie_r, auto_rts_r, ovr_r, fe_r, rts_r, intr_r, rts_eff_s, tx_busy_s;
  logic [15:0] div_r, presc_r;
  logic tick_s;
  logic [7:0] rd_data_s;
  logic rxd_m_r, rxd_s_r;

  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp_r, tx_rp_r, rx_wp_r, rx_rp_r, tx_cnt_s, rx_cnt_s;
  logic tx_empty_s, tx_full_s, rx_empty_s, rx_full_s, tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic [7:0] tx_head_s, rx_head_s;

  tx_state_t tx_state_r, tx_state_n;
  logic [3:0] tx_tk_r, tx_tk_n;
  logic [2:0] tx_bit_r, tx_bit_n;
  logic [7:0] tx_sh_r, tx_sh_n;
  logic txd_r, txd_n, tx_end_s;

  rx_state_t rx_state_r, rx_state_n;
  logic [3:0] rx_tk_r, rx_tk_n;
  logic [2:0] rx_bit_r, rx_bit_n;
  logic [7:0] rx_sh_r, rx_sh_n;
  logic rx_smp_s, ovr_set_s, fe_set_s;

  assign sel_s      = !ncs && (addr[3:2] == BASE_ADDR[3:2]);
  assign wr_act_s   = sel_s && !nwr;
  assign wr_pulse_s = wr_act_s && !wr_seen_r;
  assign rd_fire_s  = rd_pend_r && nrd;
  assign stat_clr_s = rd_fire_s && (rd_idx_r == 2'd0);
  assign flush_s    = wr_pulse_s && (addr[1:0] == 2'd0) && data[7];
  assign div_wr_s   = wr_pulse_s && addr[1];
  assign tick_s     = (presc_r == div_r);

  assign tx_cnt_s   = tx_wp_r - tx_rp_r;
  assign rx_cnt_s   = rx_wp_r - rx_rp_r;
  assign tx_empty_s = (tx_cnt_s == PTR_ZERO);
  assign rx_empty_s = (rx_cnt_s == PTR_ZERO);
  assign tx_full_s  = (tx_cnt_s == DEPTH_C);
  assign rx_full_s  = (rx_cnt_s == DEPTH_C);
  assign tx_head_s  = tx_mem[tx_rp_r[AW-1:0]];
  assign rx_head_s  = rx_mem[rx_rp_r[AW-1:0]];
  assign tx_push_s  = wr_pulse_s && (addr[1:0] == 2'd1) && !tx_full_s;
  assign rx_pop_s   = rd_fire_s && (rd_idx_r == 2'd1) && !rx_empty_s;

  assign tx_busy_s  = !tx_empty_s || (tx_state_r != TX_IDLE);
  assign rts_eff_s  = rts_req_r && !(auto_rts_r && (rx_cnt_s >= RTS_LVL_C));
  assign tx_end_s   = tick_s && (tx_tk_r == 4'd15);
  assign rx_smp_s   = tick_s && (rx_tk_r == 4'd15);

  assign data       = (sel_s && !nrd) ? rd_data_s : 8'hzz;
  assign txd_serial = txd_r;
  assign rts_serial = rts_r;
  assign intr_out   = intr_r;

  // Register read mux; an empty RX FIFO reads as zero
  always_comb begin
    rd_data_s = 8'h00;
    case (addr[1:0])
      2'd0:    rd_data_s = {2'b00, rts_eff_s, fe_r, ovr_r, tx_full_s, tx_busy_s, !rx_empty_s};
      2'd1:    rd_data_s = rx_empty_s ? 8'h00 : rx_head_s;
      2'd2:    rd_data_s = div_r[7:0];
      default: rd_data_s = div_r[15:8];
    endcase
  end

  // Bus strobe edge tracking: one write per access, read side effects after nrd rises
  always_ff @(posedge cpuclk or negedge nrst) begin
    if (!nrst) begin
      wr_seen_r <= 1'b0;
      rd_pend_r <= 1'b0;
      rd_idx_r  <= 2'd0;
    end else begin
      wr_seen_r <= !nwr && (wr_seen_r || wr_act_s);
      if (sel_s && !nrd) begin
        rd_pend_r <= 1'b1;
        rd_idx_r  <= addr[1:0];
      end else if (nrd) begin
        rd_pend_r <= 1'b0;
      end
    end
  end

  // Control, divisor, prescaler, sticky flags and registered pin outputs
  always_ff @(posedge cpuclk or negedge nrst) begin
    if (!nrst) begin
      {auto_rts_r, tx_ie_r, rx_ie_r, rts_req_r} <= 4'b0000;
      div_r   <= DEFAULT_DIV;
      presc_r <= 16'd0;
      ovr_r   <= 1'b0;
      fe_r    <= 1'b0;
      rts_r   <= 1'b1;
      intr_r  <= 1'b0;
      rxd_m_r <= 1'b1;
      rxd_s_r <= 1'b1;
    end else begin
      if (wr_pulse_s && (addr[1:0] == 2'd0)) {auto_rts_r, tx_ie_r, rx_ie_r, rts_req_r} <= data[3:0];
      if (wr_pulse_s && (addr[1:0] == 2'd2)) div_r[7:0] <= data;
      if (wr_pulse_s && (addr[1:0] == 2'd3)) div_r[15:8] <= data;
      presc_r <= (div_wr_s || tick_s) ? 16'd0 : presc_r + 16'd1;
      ovr_r   <= ovr_set_s || (ovr_r && !stat_clr_s);
      fe_r    <= fe_set_s || (fe_r && !stat_clr_s);
      rts_r   <= !rts_eff_s;
      intr_r  <= (rx_ie_r && (!rx_empty_s || ovr_r || fe_r)) || (tx_ie_r && !tx_busy_s);
      rxd_m_r <= rxd_serial;
      rxd_s_r <= rxd_m_r;
    end
  end

  // FIFO pointers; flush empties both queues
  always_ff @(posedge cpuclk or negedge nrst) begin
    if (!nrst) begin
      {tx_wp_r, tx_rp_r, rx_wp_r, rx_rp_r} <= {4{PTR_ZERO}};
    end else if (flush_s) begin
      {tx_wp_r, tx_rp_r, rx_wp_r, rx_rp_r} <= {4{PTR_ZERO}};
    end else begin
      tx_wp_r <= tx_wp_r + (AW+1)'(tx_push_s);
      tx_rp_r <= tx_rp_r + (AW+1)'(tx_pop_s);
      rx_wp_r <= rx_wp_r + (AW+1)'(rx_push_s);
      rx_rp_r <= rx_rp_r + (AW+1)'(rx_pop_s);
    end
  end

  // FIFO storage
  always_ff @(posedge cpuclk) begin
    if (tx_push_s) tx_mem[tx_wp_r[AW-1:0]] <= data;
    if (rx_push_s) rx_mem[rx_wp_r[AW-1:0]] <= rx_sh_r;
  end

  // TX next state: start, 8 data bits LSB first, stop; reload from the stop bit for gapless frames
  always_comb begin
    tx_state_n = tx_state_r;
    tx_tk_n    = tick_s ? tx_tk_r + 4'd1 : tx_tk_r;
    tx_bit_n   = tx_bit_r;
    tx_sh_n    = tx_sh_r;
    txd_n      = txd_r;
    tx_pop_s   = 1'b0;
    if (flush_s) begin
      tx_state_n = TX_IDLE;
      txd_n      = 1'b1;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          if (!tx_empty_s) begin
            tx_pop_s   = 1'b1;
            tx_sh_n    = tx_head_s;
            tx_tk_n    = 4'd0;
            txd_n      = 1'b0;
            tx_state_n = TX_START;
          end else begin
            txd_n = 1'b1;
          end
        end
        TX_START: begin
          if (tx_end_s) begin
            tx_state_n = TX_DATA;
            tx_bit_n   = 3'd0;
            txd_n      = tx_sh_r[0];
          end else begin
            tx_state_n = TX_START;
          end
        end
        TX_DATA: begin
          if (tx_end_s && (tx_bit_r == 3'd7)) begin
            tx_state_n = TX_STOP;
            txd_n      = 1'b1;
          end else if (tx_end_s) begin
            tx_bit_n = tx_bit_r + 3'd1;
            tx_sh_n  = {1'b0, tx_sh_r[7:1]};
            txd_n    = tx_sh_r[1];
          end else begin
            tx_state_n = TX_DATA;
          end
        end
        TX_STOP: begin
          if (tx_end_s && !tx_empty_s) begin
            tx_pop_s   = 1'b1;
            tx_sh_n    = tx_head_s;
            txd_n      = 1'b0;
            tx_state_n = TX_START;
          end else if (tx_end_s) begin
            tx_state_n = TX_IDLE;
          end else begin
            tx_state_n = TX_STOP;
          end
        end
        default: begin
          tx_state_n = TX_IDLE;
          txd_n      = 1'b1;
        end
      endcase
    end
  end

  // RX next state: start validated at mid-bit, then one sample every 16 ticks
  always_comb begin
    rx_state_n = rx_state_r;
    rx_tk_n    = tick_s ? rx_tk_r + 4'd1 : rx_tk_r;
    rx_bit_n   = rx_bit_r;
    rx_sh_n    = rx_sh_r;
    rx_push_s  = 1'b0;
    ovr_set_s  = 1'b0;
    fe_set_s   = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (!rxd_s_r) begin
          rx_state_n = RX_START;
          rx_tk_n    = 4'd0;
        end else begin
          rx_state_n = RX_IDLE;
        end
      end
      RX_START: begin
        if (tick_s && (rx_tk_r == 4'd7)) begin
          rx_state_n = rxd_s_r ? RX_IDLE : RX_DATA;
          rx_tk_n    = 4'd0;
          rx_bit_n   = 3'd0;
        end else begin
          rx_state_n = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_smp_s) begin
          rx_sh_n    = {rxd_s_r, rx_sh_r[7:1]};
          rx_bit_n   = rx_bit_r + 3'd1;
          rx_state_n = (rx_bit_r == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          rx_state_n = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_smp_s && rxd_s_r) begin
          rx_state_n = RX_IDLE;
          rx_push_s  = !rx_full_s;
          ovr_set_s  = rx_full_s;
        end else if (rx_smp_s) begin
          rx_state_n = RX_BREAK;
          fe_set_s   = 1'b1;
        end else begin
          rx_state_n = RX_STOP;
        end
      end
      RX_BREAK: rx_state_n = rxd_s_r ? RX_IDLE : RX_BREAK;
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  // TX and RX state registers
  always_ff @(posedge cpuclk or negedge nrst) begin
    if (!nrst) begin
      tx_state_r <= TX_IDLE;
      tx_tk_r    <= 4'd0;
      tx_bit_r   <= 3'd0;
      tx_sh_r    <= 8'h00;
      txd_r      <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_tk_r    <= 4'd0;
      rx_bit_r   <= 3'd0;
      rx_sh_r    <= 8'h00;
    end else begin
      tx_state_r <= tx_state_n;
      tx_tk_r    <= tx_tk_n;
      tx_bit_r   <= tx_bit_n;
      tx_sh_r    <= tx_sh_n;
      txd_r      <= txd_n;
      rx_state_r <= rx_state_n;
      rx_tk_r    <= rx_tk_n;
      rx_bit_r   <= rx_bit_n;
      rx_sh_r    <= rx_sh_n;
    end
  end
endmodule

// File: doc/serial_fifo_uart.md
Name: serial_fifo_uart

Overview:
- Second-generation CPU-mapped UART for the Kraft80 video/IO FPGA. It uses the same Z80-style strobe bus: data, ncs, nwr, nrd, addr.
- Adds a programmable 16-bit baud divisor, 16x oversampled RX with mid-bit sampling, parametrised RX/TX FIFOs, error flags, auto-RTS flow control and two interrupt sources.
- Drives the board serial pins and one interrupt line into the CPU interrupt merge logic.

Parameters:
- FIFO_DEPTH, 16, entries per FIFO. Power of two, 2..256.
- BASE_ADDR, 8, 4-bit base address. The block decodes when addr[3:2]==BASE_ADDR[3:2].
- DEFAULT_DIV, 12, reset value of the divisor register. Oversample tick period is DIV+1 cpuclk cycles. 12 gives 19200 bps at 4 MHz.
- AUTO_RTS_LEVEL, FIFO_DEPTH-2, RX FIFO count at or above which auto-RTS deasserts.

Ports:
- cpuclk  input  1  system clock (4 MHz nominal)
- nrst  input  1  reset, asynchronous, active-low
- data  inout  8  CPU data bus. Driven only while the block is selected and nrd is low; Z otherwise.
- ncs  input  1  IO chip select, active-low
- nwr  input  1  write strobe, active-low
- nrd  input  1  read strobe, active-low
- addr  input  4  IO address low nibble
- rxd_serial  input  1  serial RX. Asynchronous; double-flop synchronised internally.
- txd_serial  output  1  serial TX, idle high
- rts_serial  output  1  RTS, active-low
- intr_out  output  1  interrupt request, active-high

Behaviour:
- Select: sel = !ncs && addr[3:2]==BASE_ADDR[3:2]. Register index is addr[1:0].
- Registers:
  - 0 read STATUS.
  - 0 write CONTROL.
  - 1 read RXDATA (pop).
  - 1 write TXDATA (push).
  - 2 read/write DIV[7:0].
  - 3 read/write DIV[15:8].
- STATUS bits:
  - 0 rx_not_empty
  - 1 tx_busy (TX FIFO non-empty or shifter active)
  - 2 tx_full
  - 3 overrun (sticky)
  - 4 framing_err (sticky)
  - 5 rts_effective (1 = RTS asserted)
  - 7:6 zero
- CONTROL bits (write-only):
  - 0 rts_req
  - 1 rx_ie
  - 2 tx_ie
  - 3 auto_rts
  - 7 flush: self-clearing; empties both FIFOs and aborts the TX shifter, with txd_serial returned to 1 on the next cycle.
- Write action: occurs once per access, on the first cpuclk edge where sel && !nwr. No repeat until nwr deasserts.
- Read side effects: occur once, on the first edge after the read strobe deasserts, i.e. the sample edge that sees nrd high after a selected read.
  - Index 1 pops the RX FIFO if non-empty.
  - Index 0 clears overrun and framing_err, unless the same flag is being set on that cycle; set wins.
- Read data: combinational from current state.
  - RXDATA shows the FIFO head.
  - Reading an empty RX FIFO returns 0x00 and does not pop.
- TX push when full: byte dropped, no flag. Push and shifter-pop in the same cycle is legal.
- Baud tick: a 16-bit prescaler counts 0..DIV and issues a single-cycle tick at the wrap. Writing either DIV byte zeroes the prescaler. DIV=0 gives a tick every cycle.
- RX FSM, counting in ticks:
  - IDLE: synchronised rxd=0 -> START, with sample count 0.
  - START: at count 7, rxd=1 -> IDLE (glitch); else -> DATA with count reset.
  - DATA: sample every 16 ticks, LSB first, 8 bits -> STOP.
  - STOP: sample after 16 ticks.
    - rxd=1 and FIFO not full: push.
    - FIFO full: set overrun, drop byte.
    - rxd=0: set framing_err, drop byte, wait for rxd=1 before returning to IDLE.
- TX FSM, 16 ticks per bit:
  - IDLE pops the FIFO when non-empty.
  - Sends start 0, then D0..D7, then stop 1, then back to IDLE. Back-to-back bytes have no idle gap.
  - The stop bit lasts a full 16 ticks.
- RTS: rts_serial = ~(rts_req && !(auto_rts && rx_count >= AUTO_RTS_LEVEL)).
- Interrupt: intr_out = rx_ie && (rx_not_empty || overrun || framing_err) || tx_ie && !tx_busy. Registered, so it lags its cause by 1 cycle.
- Reset (async, any time, including mid-frame):
  - FIFOs empty, FSMs IDLE, flags and CONTROL zero, DIV = DEFAULT_DIV.
  - txd_serial = 1, rts_serial = 1, intr_out = 0, data = Z.

Test Plan:
- Reset, then read STATUS -> 0x00. Read DIV -> 0x0C, 0x00. txd_serial=1, rts_serial=1, intr_out=0.
- Write TXDATA 0x55 then 0xA3 with DIV=12 -> txd shows start, 1010 1010, stop, then start, 1100 0101, stop. Each bit is 208 cycles, with no gap between frames. tx_busy clears after the second stop bit.
- Drive RX frame 0x3C at 19200 bps with +3% skew -> rx_not_empty=1. With rx_ie=1, intr_out rises. RXDATA read returns 0x3C; after the read strobe ends, rx_not_empty=0.
- Send FIFO_DEPTH+1 frames without reading -> overrun=1 and the first 16 bytes are intact. With auto_rts=1, rts_serial goes high once 14 bytes are queued. STATUS read clears overrun.
- RX frame with stop bit 0 -> framing_err=1 and no push. A 3-tick low glitch on idle line -> no START accepted.
- Assert nrst mid TX frame and mid RX frame -> txd_serial=1 immediately. The next frame after release is received and transmitted correctly.
